// File: rtl/block_ram_pipelined.sv
// rtl/block_ram_pipelined.sv - simple dual-port byte-writable block RAM with post-reset clear and 1/2-cycle read pipeline
//
// Ports:
//   clock              rising-edge clock
//   reset_n            async active-low reset (outputs, pipeline, FSM; not the array)
//   write_address      write word address
//   write              write strobe
//   write_byte_enable  per-lane write enables, lane i = write_data[i*BYTE_WIDTH +: BYTE_WIDTH]
//   write_data         write data
//   read_address       read word address
//   read               read strobe
//   read_data          read result, zero whenever read_valid is low
//   read_valid         one-cycle pulse per accepted read
//   ready              high once the clear engine has finished; traffic accepted
module block_ram_pipelined #(
  parameter int WORD_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 10,
  parameter int BYTE_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,
  parameter int RDW_NEW_DATA   = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int NUM_BYTES     = WORD_WIDTH / BYTE_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [ADDRESS_WIDTH-1:0] write_address,
  input  logic                     write,
  input  logic [NUM_BYTES-1:0]     write_byte_enable,
  input  logic [WORD_WIDTH-1:0]    write_data,
  input  logic [ADDRESS_WIDTH-1:0] read_address,
  input  logic                     read,
  output logic [WORD_WIDTH-1:0]    read_data,
  output logic                     read_valid,
  output logic                     ready
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH:0] LAST_ADDR = {1'b0, {ADDRESS_WIDTH{1'b1}}};

  generate
    if (WORD_WIDTH % BYTE_WIDTH != 0) begin : g_bad_word_width
      $error("block_ram_pipelined: WORD_WIDTH must be a multiple of BYTE_WIDTH");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_read_latency
      $error("block_ram_pipelined: READ_LATENCY must be 1 or 2");
    end
  endgenerate

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;

  state_t                 state;
  state_t                 state_next;
  logic [ADDRESS_WIDTH:0] counter;
  logic [ADDRESS_WIDTH:0] counter_next;

  logic [WORD_WIDTH-1:0]  mem [DEPTH];

  logic                   run;
  logic                   read_issue;
  logic                   rdw_hit;
  logic [WORD_WIDTH-1:0]  old_word;
  logic [WORD_WIDTH-1:0]  read_word;
  logic [WORD_WIDTH-1:0]  s1_data;
  logic                   s1_valid;

  // FSM state register; ready is registered so it rises on the edge entering RUN.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RESET_STATE;
      counter <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      ready   <= (state_next == RUN);
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    case (state)
      CLEAR: begin
        counter_next = counter + 1'b1;
        if (counter == LAST_ADDR) begin
          state_next = RUN;
        end
      end
      RUN: begin
        state_next = RUN;
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

  assign run        = (state == RUN);
  assign read_issue = run & read;
  assign rdw_hit    = run & write & (write_address == read_address);
  assign old_word   = mem[read_address];

  // Array write port. Held off while reset is asserted so a held reset never
  // disturbs contents. The clear engine owns the port during CLEAR.
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (state == CLEAR) begin
        mem[counter[ADDRESS_WIDTH-1:0]] <= '0;
      end else if (write) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
          if (write_byte_enable[i]) begin
            mem[write_address][i*BYTE_WIDTH +: BYTE_WIDTH] <= write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  // Read-during-write to the same word: optionally forward the enabled lanes
  // of the incoming write over the old word.
  always_comb begin
    read_word = old_word;
    if (RDW_NEW_DATA != 0 && rdw_hit) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (write_byte_enable[i]) begin
          read_word[i*BYTE_WIDTH +: BYTE_WIDTH] = write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // First read stage; an edge with no issued read loads a zero bubble.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_data  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= read_issue;
      s1_data  <= read_issue ? read_word : '0;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_latency2
      logic [WORD_WIDTH-1:0] s2_data;
      logic                  s2_valid;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          s2_data  <= '0;
          s2_valid <= 1'b0;
        end else begin
          s2_valid <= s1_valid;
          s2_data  <= s1_valid ? s1_data : '0;
        end
      end

      assign read_data  = s2_data;
      assign read_valid = s2_valid;
    end else begin : g_latency1
      assign read_data  = s1_data;
      assign read_valid = s1_valid;
    end
  endgenerate

endmodule

// File: tb/tb_block_ram_pipelined.sv
// tb/tb_block_ram_pipelined.sv - scoreboard bench driving three RAM configurations with shared random traffic
module tb_block_ram_pipelined;

  // DUT 0: latency 1, new-data RDW, clear on reset
  // DUT 1: latency 2, old-data RDW, clear on reset
  // DUT 2: latency 2, new-data RDW, no clear
  localparam int ND = 3;

  logic        clock;
  logic        reset_n;
  logic [3:0]  wa;
  logic        wr;
  logic [3:0]  be;
  logic [31:0] wd;
  logic [3:0]  ra;
  logic        rd;

  logic [31:0] rdata  [ND];
  logic        rvalid [ND];
  logic        rdy    [ND];

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    int          due;
  } exp_t;

  exp_t        sb [ND][$];
  logic [31:0] mm [ND][16];
  logic [31:0] km [ND][16];

  int compared;
  int mismatched;
  int cyc;
  int n;

  exp_t mon_e;
  logic mon_rdy;

  block_ram_pipelined #(
    .WORD_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8),
    .READ_LATENCY(1), .RDW_NEW_DATA(1), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clock(clock), .reset_n(reset_n),
    .write_address(wa), .write(wr), .write_byte_enable(be), .write_data(wd),
    .read_address(ra), .read(rd),
    .read_data(rdata[0]), .read_valid(rvalid[0]), .ready(rdy[0])
  );

  block_ram_pipelined #(
    .WORD_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8),
    .READ_LATENCY(2), .RDW_NEW_DATA(0), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clock(clock), .reset_n(reset_n),
    .write_address(wa), .write(wr), .write_byte_enable(be), .write_data(wd),
    .read_address(ra), .read(rd),
    .read_data(rdata[1]), .read_valid(rvalid[1]), .ready(rdy[1])
  );

  block_ram_pipelined #(
    .WORD_WIDTH(32), .ADDRESS_WIDTH(4), .BYTE_WIDTH(8),
    .READ_LATENCY(2), .RDW_NEW_DATA(1), .CLEAR_ON_RESET(0)
  ) dut_c (
    .clock(clock), .reset_n(reset_n),
    .write_address(wa), .write(wr), .write_byte_enable(be), .write_data(wd),
    .read_address(ra), .read(rd),
    .read_data(rdata[2]), .read_valid(rvalid[2]), .ready(rdy[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  function automatic bit new_rdw(input int d);
    return d != 1;
  endfunction

  function automatic bit clears(input int d);
    return d != 2;
  endfunction

  // Reference model: n counts edges since reset release. A clearing RAM spends
  // edges 1..16 zeroing its 16 words, so it accepts traffic from edge 17.
  always @(posedge clock) begin
    cyc++;
    if (reset_n) begin
      n++;
      for (int d = 0; d < ND; d++) begin
        if (!clears(d) || n > 16) begin
          if (rd) begin
            exp_t e;
            e.data = mm[d][ra];
            e.mask = km[d][ra];
            if (wr && wa == ra && new_rdw(d)) begin
              for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                  e.data[i*8 +: 8] = wd[i*8 +: 8];
                  e.mask[i*8 +: 8] = 8'hFF;
                end
              end
            end
            e.due = cyc + lat(d) - 1;
            sb[d].push_back(e);
          end
          if (wr) begin
            for (int i = 0; i < 4; i++) begin
              if (be[i]) begin
                mm[d][wa][i*8 +: 8] = wd[i*8 +: 8];
                km[d][wa][i*8 +: 8] = 8'hFF;
              end
            end
          end
        end
      end
    end
  end

  // Monitor: checks ready every cycle, pops the scoreboard on each read_valid.
  always @(negedge clock) begin
    for (int d = 0; d < ND; d++) begin
      mon_rdy = reset_n && (clears(d) ? (n >= 16) : (n >= 1));
      compared++;
      if (rdy[d] !== mon_rdy) begin
        mismatched++;
        $display("FAIL ready dut%0d cyc %0d: got %0b want %0b", d, cyc, rdy[d], mon_rdy);
      end
      if (rvalid[d]) begin
        compared++;
        if (sb[d].size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_valid dut%0d cyc %0d: got valid=1 data=%h want valid=0", d, cyc, rdata[d]);
        end else begin
          mon_e = sb[d].pop_front();
          if (mon_e.due != cyc || ((rdata[d] ^ mon_e.data) & mon_e.mask) != 32'h0) begin
            mismatched++;
            $display("FAIL read_data dut%0d cyc %0d: got %h (cyc %0d) want %h mask %h (cyc %0d)",
                     d, cyc, rdata[d], cyc, mon_e.data, mon_e.mask, mon_e.due);
          end
        end
      end else begin
        compared++;
        if (rdata[d] !== 32'h0) begin
          mismatched++;
          $display("FAIL idle_data dut%0d cyc %0d: got %h want 00000000", d, cyc, rdata[d]);
        end
        if (sb[d].size() > 0 && sb[d][0].due <= cyc) begin
          compared++;
          mismatched++;
          mon_e = sb[d].pop_front();
          $display("FAIL missing_valid dut%0d cyc %0d: got valid=0 want data %h", d, cyc, mon_e.data);
        end
      end
    end
  end

  task automatic drive(input logic w, input logic [3:0] wa_i, input logic [3:0] be_i,
                       input logic [31:0] wd_i, input logic r, input logic [3:0] ra_i);
    @(negedge clock);
    #1;
    wr = w;
    wa = wa_i;
    be = be_i;
    wd = wd_i;
    rd = r;
    ra = ra_i;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic rand_op();
    logic [3:0] a;
    a = 4'($urandom_range(0, 15));
    drive(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom,
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 2) == 0) ? a : 4'($urandom_range(0, 15)));
  endtask

  task automatic assert_reset();
    #2;
    reset_n = 1'b0;
    n = 0;
    for (int d = 0; d < ND; d++) sb[d].delete();
    #1;
    for (int d = 0; d < ND; d++) begin
      compared++;
      if (rvalid[d] !== 1'b0 || rdata[d] !== 32'h0 || rdy[d] !== 1'b0) begin
        mismatched++;
        $display("FAIL async_reset dut%0d: got valid=%0b data=%h ready=%0b want all 0",
                 d, rvalid[d], rdata[d], rdy[d]);
      end
    end
  endtask

  task automatic release_reset();
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    n = 0;
    for (int d = 0; d < ND; d++) begin
      if (clears(d)) begin
        for (int a = 0; a < 16; a++) begin
          mm[d][a] = 32'h0;
          km[d][a] = 32'hFFFF_FFFF;
        end
      end
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    cyc        = 0;
    n          = 0;
    reset_n    = 1'b0;
    wr = 1'b0; wa = '0; be = '0; wd = '0; rd = 1'b0; ra = '0;
    for (int d = 0; d < ND; d++) begin
      for (int a = 0; a < 16; a++) begin
        mm[d][a] = 32'h0;
        km[d][a] = 32'h0;
      end
    end

    repeat (3) idle();
    release_reset();
    // Traffic during clear, then reset mid-clear after edge 9.
    repeat (9) rand_op();
    assert_reset();
    repeat (2) idle();
    release_reset();
    repeat (16) rand_op();

    // Every address reads back zero after the clear.
    for (int a = 0; a < 16; a++) drive(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));

    // Byte enables.
    drive(1'b1, 4'd5, 4'b1111, 32'hAABB_CCDD, 1'b0, 4'd0);
    drive(1'b1, 4'd5, 4'b0101, 32'h1122_3344, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 4'b0000, 32'h0, 1'b1, 4'd5);
    drive(1'b1, 4'd5, 4'b0000, 32'hDEAD_BEEF, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 4'b0000, 32'h0, 1'b1, 4'd5);

    // Read-during-write on a zero word.
    drive(1'b1, 4'd7, 4'b0011, 32'hFFFF_FFFF, 1'b1, 4'd7);
    drive(1'b0, 4'd0, 4'b0000, 32'h0, 1'b1, 4'd7);

    // Back-to-back reads and bubbles.
    drive(1'b0, 4'd0, 4'b0000, 32'h0, 1'b1, 4'd1);
    drive(1'b0, 4'd0, 4'b0000, 32'h0, 1'b1, 4'd2);
    drive(1'b0, 4'd0, 4'b0000, 32'h0, 1'b1, 4'd3);
    idle();
    drive(1'b0, 4'd0, 4'b0000, 32'h0, 1'b1, 4'd5);
    repeat (2) idle();

    repeat (1500) rand_op();

    // Reset while reads are in flight.
    drive(1'b1, 4'd9, 4'b1111, 32'h1234_5678, 1'b1, 4'd9);
    assert_reset();
    repeat (2) idle();
    release_reset();
    repeat (20) rand_op();
    repeat (600) rand_op();

    repeat (4) idle();
    for (int d = 0; d < ND; d++) begin
      compared++;
      if (sb[d].size() != 0) begin
        mismatched++;
        $display("FAIL drain dut%0d: got %0d pending reads want 0", d, sb[d].size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
